dram_line_bridge: RTL

//  CPU-word to AXI4 single-beat bridge for the MIG DDR2 port, parametrised in address and AXI data width.

---
 rtl/dram_line_bridge.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/dram_line_bridge.sv
// dram_line_bridge: CPU word port to single-beat AXI4 bridge for the MIG DDR2 port,
// with a direct-mapped write-through read line buffer and sticky response-error capture.
module dram_line_bridge #(
  parameter int ADDR_W = 32,
  parameter int AXI_DW = 128,
  parameter int LINES  = 4,
  parameter int BUF_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dram_oe,
  input  logic [ADDR_W-1:0]     dram_addr,
  input  logic [31:0]           dram_wdata,
  input  logic [3:0]            dram_we,
  output logic [31:0]           dram_rdata,
  output logic                  dram_valid,
  output logic                  dram_busy,
  output logic                  dram_err,
  input  logic                  err_clr,
  input  logic                  flush,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_DW-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [AXI_DW-1:0]     m_axi_wdata,
  output logic [AXI_DW/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SW    = AXI_DW / 8;
  localparam int OFF   = $clog2(SW);
  localparam int LANES = AXI_DW / 32;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDX   = $clog2(LINES);
  localparam int IDXW  = (IDX > 0) ? IDX : 1;
  localparam int TAG_W = ADDR_W - OFF - IDX;
  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
  state_t state, state_nx;

  logic [AXI_DW-1:0] line_data [LINES];
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [LINES-1:0]  line_valid;

  logic [TAG_W-1:0]  a_tag, req_tag;
  logic [IDXW-1:0]   a_idx, req_idx;
  logic [LW-1:0]     a_lane, req_lane;
  logic [1:0]        a_off, req_off;
  logic [ADDR_W-1:0] a_line_addr;
  logic              fill_kill;

  assign a_tag       = dram_addr[ADDR_W-1:OFF+IDX];
  assign a_off       = dram_addr[1:0];
  assign a_line_addr = {dram_addr[ADDR_W-1:OFF], {OFF{1'b0}}};

  generate
    if (IDX > 0) begin : g_idx
      assign a_idx = dram_addr[OFF+IDX-1:OFF];
    end else begin : g_noidx
      assign a_idx = '0;
    end
    if (LANES > 1) begin : g_lane
      assign a_lane = dram_addr[OFF-1:2];
    end else begin : g_nolane
      assign a_lane = '0;
    end
  endgenerate

  logic req, rd_req, wr_req, line_hit, rd_hit, fill_ok;
  assign req      = (state == IDLE) && dram_oe;
  assign rd_req   = req && (dram_we == 4'b0000);
  assign wr_req   = req && (dram_we != 4'b0000);
  assign line_hit = (BUF_EN != 0) && line_valid[a_idx] && (line_tag[a_idx] == a_tag);
  assign rd_hit   = line_hit && !flush;
  assign fill_ok  = (BUF_EN != 0) && (state == RD) && m_axi_rvalid && (m_axi_rresp == OKAY)
                    && !flush && !fill_kill;

  // Write word positioned in its lane; bytes pushed past the word boundary fall off.
  logic [31:0]       wr_word;
  logic [7:0]        wr_be8;
  logic [AXI_DW-1:0] wr_data;
  logic [SW-1:0]     wr_strb;
  assign wr_word = dram_wdata << {a_off, 3'b000};
  assign wr_be8  = {4'b0000, dram_we} << a_off;
  assign wr_data = AXI_DW'(wr_word) << {a_lane, 5'b00000};
  assign wr_strb = SW'(wr_be8[3:0]) << {a_lane, 2'b00};

  logic [31:0] hit_word, fill_word;
  assign hit_word  = 32'(line_data[a_idx] >> {a_lane, 5'b00000}) >> {a_off, 3'b000};
  assign fill_word = 32'(m_axi_rdata >> {req_lane, 5'b00000}) >> {req_off, 3'b000};

  assign dram_busy    = (state != IDLE);
  assign m_axi_rready = (state == RD);
  assign m_axi_bready = (state == WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (rd_req && !rd_hit) state_nx = RD;
               else if (wr_req)      state_nx = WR;
      RD:      if (m_axi_rvalid)     state_nx = IDLE;
      WR:      if (m_axi_bvalid)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_rdata    <= '0;
      dram_valid    <= 1'b0;
      dram_err      <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      req_tag       <= '0;
      req_idx       <= '0;
      req_lane      <= '0;
      req_off       <= '0;
      fill_kill     <= 1'b0;
    end else begin
      dram_valid <= 1'b0;
      // Clear first so a same-cycle error event below takes precedence.
      if (err_clr) dram_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            req_tag  <= a_tag;
            req_idx  <= a_idx;
            req_lane <= a_lane;
            req_off  <= a_off;
          end
          fill_kill <= 1'b0;
          if (rd_req) begin
            if (rd_hit) begin
              dram_rdata <= hit_word;
              dram_valid <= 1'b1;
            end else begin
              m_axi_araddr  <= a_line_addr;
              m_axi_arvalid <= 1'b1;
            end
          end else if (wr_req) begin
            m_axi_awaddr  <= a_line_addr;
            m_axi_awvalid <= 1'b1;
            m_axi_wdata   <= wr_data;
            m_axi_wstrb   <= wr_strb;
            m_axi_wvalid  <= 1'b1;
          end
        end
        RD: begin
          if (flush) fill_kill <= 1'b1;
          if (m_axi_arready) m_axi_arvalid <= 1'b0;
          if (m_axi_rvalid) begin
            m_axi_arvalid <= 1'b0;
            dram_rdata    <= fill_word;
            dram_valid    <= 1'b1;
            if (m_axi_rresp != OKAY) dram_err <= 1'b1;
          end
        end
        WR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (m_axi_bvalid) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            if (m_axi_bresp != OKAY) dram_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid <= '0;
    end else begin
      if (fill_ok) line_valid[req_idx] <= 1'b1;
      if ((state == WR) && m_axi_bvalid && (m_axi_bresp != OKAY) && (line_tag[req_idx] == req_tag))
        line_valid[req_idx] <= 1'b0;
      if (flush) line_valid <= '0;
    end
  end

  // Line contents carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if ((state == RD) && m_axi_rvalid && (m_axi_rresp == OKAY)) begin
      line_data[req_idx] <= m_axi_rdata;
      line_tag[req_idx]  <= req_tag;
    end
    if (wr_req && line_hit) begin
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) line_data[a_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
